lc3b_mem_responder: RTL and testbench

Memory-side responder for the LC-3b multicycle core's memory request interface. It accepts mem_read and mem_write requests from the control unit and datapath, and services them from an internal 16-bit word array after a programmable wait. It returns mem_resp and mem_rdata with the level-hold semantics the control FSM expects. It is used as the simulation/FPGA main memory behind the core.

---
 rtl/lc3b_mem_responder.sv | 130 +++++++++++++
 tb/tb_lc3b_mem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_responder.sv
// Word-organised main memory behind the LC-3b multicycle core. It services mem_read/mem_write
// after a programmable wait and returns a one-cycle mem_resp with a held mem_rdata.
module lc3b_mem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_resp,
    output logic        protocol_err
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] wdata;
        logic [1:0]        be;
        logic              is_write;
    } req_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    req_t               req_q, req_d;
    logic               resp_d;
    logic               rd_load_c;
    logic               we_c;
    logic               req_held_c;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    // Byte-address bit 0 and bits above the word index alias onto the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_address[15:ADDR_W+1], mem_address[0]};

    // A simultaneous read+write is flagged while it is being accepted in IDLE.
    assign protocol_err = (state_q == S_IDLE) & mem_read & mem_write;

    // Abort detection follows the request line that was accepted.
    assign req_held_c = req_q.is_write ? mem_write : mem_read;

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        resp_d    = 1'b0;
        rd_load_c = 1'b0;
        we_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    req_d.idx      = mem_address[ADDR_W:1];
                    req_d.wdata    = mem_wdata;
                    req_d.be       = mem_byte_enable;
                    req_d.is_write = mem_write & ~mem_read;
                    cnt_d          = CNT_W'(LATENCY - 1);
                    state_d        = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req_held_c) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d   = S_RESP;
                    resp_d    = 1'b1;
                    we_c      = req_q.is_write;
                    rd_load_c = ~req_q.is_write;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            mem_resp  <= 1'b0;
            mem_rdata <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            mem_resp <= resp_d;
            if (rd_load_c) begin
                mem_rdata <= mem_q[req_q.idx];
            end
        end
    end

    // Storage array; contents survive reset, writes land as RESP is entered.
    always_ff @(posedge clk) begin
        if (we_c) begin
            if (req_q.be[0]) begin
                mem_q[req_q.idx][7:0] <= req_q.wdata[7:0];
            end
            if (req_q.be[1]) begin
                mem_q[req_q.idx][15:8] <= req_q.wdata[15:8];
            end
        end
    end

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Scoreboard bench for lc3b_mem_responder: the driver queues expected responses and
// a negedge monitor matches every mem_resp / protocol_err pulse against them.
module tb_lc3b_mem_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic        protocol_err;

    lc3b_mem_responder #(.ADDR_W(10), .LATENCY(LAT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .protocol_err    (protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          is_rd;
        logic [15:0] data;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          perr_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_rd = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output pulse must match the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        int   pc;
        if (!rst_n) last_rd = 16'h0000;
        if (mem_resp) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: mem_resp=1 at cycle %0d, required no response", cyc);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.due) begin
                    errors++;
                    $display("FAIL %s_latency: resp at cycle %0d, required cycle %0d", e.name, cyc, e.due);
                end
                checks++;
                if (e.is_rd) begin
                    if (mem_rdata !== e.data) begin
                        errors++;
                        $display("FAIL %s_rdata: got %h, required %h", e.name, mem_rdata, e.data);
                    end
                    last_rd = e.data;
                end else if (mem_rdata !== last_rd) begin
                    errors++;
                    $display("FAIL %s_rdata_hold: got %h, required %h", e.name, mem_rdata, last_rd);
                end
            end
        end
        if (protocol_err) begin
            checks++;
            if (perr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_perr: protocol_err=1 at cycle %0d, required 0", cyc);
            end else begin
                pc = perr_q.pop_front();
                if (pc != cyc) begin
                    errors++;
                    $display("FAIL perr_cycle: pulse at cycle %0d, required cycle %0d", cyc, pc);
                end
            end
        end
    end

    // Issue one request, scramble its side inputs after acceptance, hold until mem_resp.
    task automatic req(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] be,
                       input logic [15:0] exp_data, input bit early, input string name);
        int   t;
        bit   got;
        exp_t e;
        if (!early) begin
            @(posedge clk);
            #1;
        end
        t = early ? cyc + 1 : cyc;
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = a;
        mem_wdata       = d;
        mem_byte_enable = be;
        e.due   = t + LAT + 1;
        e.is_rd = rd;
        e.data  = exp_data;
        e.name  = name;
        exp_q.push_back(e);
        if (rd && wr) perr_q.push_back(t);
        repeat (early ? 2 : 1) @(posedge clk);
        #1;
        mem_address     = ~a;
        mem_wdata       = ~d;
        mem_byte_enable = ~be;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_resp) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: mem_resp=0 after 40 cycles, required 1", name);
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [15:0] rd, input logic rs, input logic pe);
        checks++;
        if (mem_rdata !== rd || mem_resp !== rs || protocol_err !== pe) begin
            errors++;
            $display("FAIL %s: rdata=%h resp=%b perr=%b, required rdata=%h resp=%b perr=%b",
                     name, mem_rdata, mem_resp, protocol_err, rd, rs, pe);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_byte_enable = 2'b00;
        mem_address = 16'h0000;
        mem_wdata = 16'h0000;
        #12;
        check_out("reset_state", 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Write then read, plus byte masks with a back-to-back read raised in DONE.
        req(0, 1, 16'h0040, 16'hBEEF, 2'b11, 16'h0000, 0, "wr_beef");
        req(1, 0, 16'h0040, 16'h0000, 2'b00, 16'hBEEF, 0, "rd_beef");
        req(0, 1, 16'h0010, 16'h1234, 2'b11, 16'h0000, 0, "wr_1234");
        req(0, 1, 16'h0010, 16'hAB00, 2'b10, 16'h0000, 0, "wr_hi");
        req(1, 0, 16'h0010, 16'h0000, 2'b11, 16'hAB34, 0, "rd_ab34");
        req(0, 1, 16'h0011, 16'h00CD, 2'b01, 16'h0000, 0, "wr_lo");
        req(1, 0, 16'h0010, 16'h0000, 2'b00, 16'hABCD, 0, "rd_abcd");
        req(1, 0, 16'h0011, 16'h0000, 2'b00, 16'hABCD, 1, "rd_early");

        // Abort: drop mem_write in WAIT, no resp and no commit.
        req(0, 1, 16'h0020, 16'h1111, 2'b11, 16'h0000, 0, "wr_1111");
        @(posedge clk);
        #1;
        mem_write = 1'b1;
        mem_address = 16'h0020;
        mem_wdata = 16'h5555;
        mem_byte_enable = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        mem_write = 1'b0;
        repeat (8) @(posedge clk);
        req(1, 0, 16'h0020, 16'h0000, 2'b00, 16'h1111, 0, "rd_after_abort");

        // Simultaneous read+write is serviced as a read.
        req(1, 1, 16'h0040, 16'h0000, 2'b11, 16'hBEEF, 0, "rdwr_illegal");
        req(1, 0, 16'h0040, 16'h0000, 2'b00, 16'hBEEF, 0, "rd_after_illegal");

        // Aliasing wrap and a zero-mask write.
        req(0, 1, 16'h0800, 16'h7777, 2'b11, 16'h0000, 0, "wr_alias");
        req(1, 0, 16'h0000, 16'h0000, 2'b00, 16'h7777, 0, "rd_alias");
        req(0, 1, 16'h0000, 16'h1234, 2'b00, 16'h0000, 0, "wr_be00");
        req(1, 0, 16'h0800, 16'h0000, 2'b00, 16'h7777, 0, "rd_be00");

        // Asynchronous reset in WAIT of a write.
        @(posedge clk);
        #1;
        mem_write = 1'b1;
        mem_address = 16'h0040;
        mem_wdata = 16'h0BAD;
        mem_byte_enable = 2'b11;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("reset_mid_wait", 16'h0000, 1'b0, 1'b0);
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req(1, 0, 16'h0040, 16'h0000, 2'b00, 16'hBEEF, 0, "rd_after_reset");
        req(0, 1, 16'h0042, 16'hC0DE, 2'b11, 16'h0000, 0, "wr_after_reset");
        req(1, 0, 16'h0042, 16'h0000, 2'b00, 16'hC0DE, 0, "rd_c0de");

        repeat (10) @(posedge clk);
        checks++;
        if (exp_q.size() != 0 || perr_q.size() != 0) begin
            errors++;
            $display("FAIL pending_at_end: %0d resp and %0d perr outstanding, required 0",
                     exp_q.size(), perr_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
